exec_arbiter: RTL

Shares the single-cycle execute unit between two requesters (port 0: main pipeline issue, port 1: auxiliary/debug issue) under a valid/ready handshake. It captures one request, drives the exec unit's `op`/`in1`/`in2` from registered operands, latches the exec result and returns it with the winning port's ID. It sits between the requesters and the `exec` instance and does not itself compute any result.

---
 rtl/exec_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/exec_arbiter.sv
// exec_arbiter: shares a single-cycle execute unit between two requesters.
// Captures one request, issues it to the exec unit for one cycle, latches the
// result and holds it until the consumer takes it.
// Build option: EXEC_ARB_FIXED_PRIO_EN gives port 0 fixed priority on contention
// (default build uses round-robin arbitration).
module exec_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [5:0]  req0_op,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [5:0]  req1_op,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    output logic [5:0]  exec_op,
    output logic [31:0] exec_in1,
    output logic [31:0] exec_in2,
    input  logic [31:0] exec_out,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_id
);

    localparam int DATA_W = 32;
    localparam int OP_W   = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_id_q;
    logic                prio_port0;
    logic                accept;
    logic                accept_id;

    // Holding registers for the accepted request
    logic [OP_W-1:0]     op_p0;
    logic [DATA_W-1:0]   in1_p0;
    logic [DATA_W-1:0]   in2_p0;
    logic                id_p0;

`ifdef EXEC_ARB_FIXED_PRIO_EN
    assign prio_port0 = 1'b1;
`else
    // Port 0 wins a contest when port 1 was the last one served
    assign prio_port0 = last_id_q;
`endif

    assign accept    = req0_ready | req1_ready;
    assign accept_id = req1_ready;

    // Next-state, arbitration grant and exec/response outputs from the current state
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        exec_op    = '0;
        exec_in1   = '0;
        exec_in2   = '0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                // Ready is forced low while reset is asserted
                if (rst_n) begin
                    if (req0_valid && req1_valid) begin
                        req0_ready = prio_port0;
                        req1_ready = ~prio_port0;
                    end else begin
                        req0_ready = req0_valid;
                        req1_ready = req1_valid;
                    end
                end
                if (req0_ready || req1_ready) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                exec_op  = op_p0;
                exec_in1 = in1_p0;
                exec_in2 = in2_p0;
                state_d  = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register and round-robin history, updated on every accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_id_q <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_id_q <= accept_id;
            end
        end
    end

    // Capture the winning request's payload and ID on handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_p0  <= '0;
            in1_p0 <= '0;
            in2_p0 <= '0;
            id_p0  <= 1'b0;
        end else if (accept) begin
            id_p0 <= accept_id;
            if (accept_id) begin
                op_p0  <= req1_op;
                in1_p0 <= req1_in1;
                in2_p0 <= req1_in2;
            end else begin
                op_p0  <= req0_op;
                in1_p0 <= req0_in1;
                in2_p0 <= req0_in2;
            end
        end
    end

    // Latch the exec result during ISSUE; held stable through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data <= '0;
            resp_id   <= 1'b0;
        end else if (state_q == ISSUE) begin
            resp_data <= exec_out;
            resp_id   <= id_p0;
        end
    end

endmodule
